// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_word_packer
//  Description : Drains a synchronous FIFO and packs pairs of FIFO words into
//                double-width beats on a valid/ready stream. A flush emits a
//                trailing half-filled beat; rejected reads set a sticky flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_packer #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_empty,
    input  logic [FIFO_WIDTH-1:0]   fifo_data_out,
    input  logic                    fifo_underflow,
    output logic                    fifo_rd_en,
    input  logic                    flush,
    output logic [2*FIFO_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [1:0]              m_keep,
    output logic                    m_last,
    output logic                    flush_done,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic                    underflow_err
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FLUSH_WAIT = 2'd1,
        ST_FLUSH_EMIT = 2'd2
    } state_t;

    localparam logic [1:0] c_MAX_INFLIGHT = 2'd2;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_pending;
    logic [FIFO_WIDTH-1:0]   r_lo;
    logic                    r_lo_vld;
    logic [FIFO_WIDTH-1:0]   r_hi;
    logic                    r_hi_vld;

    logic [1:0]              w_inflight;
    logic                    w_out_free;
    logic                    w_word_ok;
    logic                    w_word_to_lo;
    logic                    w_word_to_out;
    logic                    w_word_to_hi;
    logic                    w_pair_to_out;
    logic                    w_flush_load;
    logic                    w_accept;

    // Words staged plus the read still in flight; never exceeds two so the
    // staging registers can always absorb whatever the FIFO returns.
    assign w_inflight = {1'b0, r_lo_vld} + {1'b0, r_hi_vld} + {1'b0, r_pending};

    assign fifo_rd_en = !rst && !fifo_empty && (r_state == ST_RUN)
                        && (w_inflight < c_MAX_INFLIGHT);

    assign w_accept      = m_valid && m_ready;
    assign w_out_free    = !m_valid || m_ready;
    assign w_word_ok     = r_pending && !fifo_underflow;
    assign w_word_to_lo  = w_word_ok && !r_lo_vld;
    assign w_word_to_out = w_word_ok && r_lo_vld && w_out_free;
    assign w_word_to_hi  = w_word_ok && r_lo_vld && !w_out_free;
    // hi is only ever valid together with lo, and no read is in flight then.
    assign w_pair_to_out = r_hi_vld && w_out_free;

    // Read tracking and staging registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_lo      <= '0;
            r_lo_vld  <= 1'b0;
            r_hi      <= '0;
            r_hi_vld  <= 1'b0;
        end else begin
            r_pending <= fifo_rd_en;
            if (w_word_to_lo) begin
                r_lo     <= fifo_data_out;
                r_lo_vld <= 1'b1;
            end else if (w_word_to_out || w_pair_to_out || w_flush_load) begin
                r_lo_vld <= 1'b0;
            end
            if (w_word_to_hi) begin
                r_hi     <= fifo_data_out;
                r_hi_vld <= 1'b1;
            end else if (w_pair_to_out) begin
                r_hi_vld <= 1'b0;
            end
        end
    end

    // Output beat register; contents hold while the beat is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_keep  <= 2'b00;
            m_last  <= 1'b0;
        end else if (w_word_to_out) begin
            m_data  <= {fifo_data_out, r_lo};
            m_valid <= 1'b1;
            m_keep  <= 2'b11;
            m_last  <= 1'b0;
        end else if (w_pair_to_out) begin
            m_data  <= {r_hi, r_lo};
            m_valid <= 1'b1;
            m_keep  <= 2'b11;
            m_last  <= 1'b0;
        end else if (w_flush_load) begin
            m_data  <= {{FIFO_WIDTH{1'b0}}, r_lo};
            m_valid <= 1'b1;
            m_keep  <= 2'b01;
            m_last  <= 1'b1;
        end else if (w_accept) begin
            m_valid <= 1'b0;
        end
    end

    // Accepted-beat counter and sticky rejected-read flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count     <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (w_accept) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (r_pending && fifo_underflow) begin
                underflow_err <= 1'b1;
            end
        end
    end

    // Flush FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush FSM: wait for in-flight data to settle, then emit any lone word.
    always_comb begin
        w_state_nxt  = r_state;
        flush_done   = 1'b0;
        w_flush_load = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (flush) begin
                    w_state_nxt = ST_FLUSH_WAIT;
                end
            end
            ST_FLUSH_WAIT: begin
                if (!r_pending && !r_hi_vld) begin
                    if (r_lo_vld) begin
                        w_state_nxt = ST_FLUSH_EMIT;
                    end else begin
                        flush_done  = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_FLUSH_EMIT: begin
                if (w_out_free) begin
                    w_flush_load = 1'b1;
                    flush_done   = 1'b1;
                    w_state_nxt  = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_word_packer
//  Description : Directed self-checking bench for fifo_word_packer with a
//                behavioural FIFO and an expected-beat scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [15:0] fifo_data_out = '0;
    logic        fifo_underflow = 1'b0;
    logic        fifo_rd_en;
    logic        flush;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  m_keep;
    logic        m_last;
    logic        flush_done;
    logic [15:0] pkt_count;
    logic        underflow_err;

    logic [15:0] mem [0:63];
    int          wp = 0;
    int          rp = 0;
    logic        inj_uf = 1'b0;

    beat_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          rd_cnt = 0;

    fifo_word_packer #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_keep(m_keep),
        .m_last(m_last), .flush_done(flush_done), .pkt_count(pkt_count),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);

    // Behavioural FIFO read port: registered data, optional rejected read.
    always @(posedge clk) begin
        fifo_underflow <= 1'b0;
        if (fifo_rd_en) begin
            if (inj_uf) begin
                fifo_underflow <= 1'b1;
            end else begin
                fifo_data_out <= mem[rp];
                rp <= rp + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        mem[wp] = w;
        wp = wp + 1;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [1:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        exp_q.push_back(b);
    endtask

    // Observe the current cycle (inputs settled), then advance one cycle.
    task automatic cycle();
        beat_t e;
        if (fifo_rd_en === 1'b1) rd_cnt++;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {31'd0, m_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", m_data, e.d);
                check("beat_keep", {30'd0, m_keep}, {30'd0, e.k});
                check("beat_last", {31'd0, m_last}, {31'd0, e.l});
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; m_ready = 1'b1;

        // ---------------- reset, then streaming ----------------
        push_word(16'h1111); push_word(16'h2222);
        push_word(16'h3333); push_word(16'h4444);
        expect_beat(32'h2222_1111, 2'b11, 1'b0);
        expect_beat(32'h4444_3333, 2'b11, 1'b0);
        @(negedge clk); #1;
        check("rst_rd_en_c0", {31'd0, fifo_rd_en}, 32'd0);
        cycle();
        check("rst_rd_en_c1", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_m_keep", {30'd0, m_keep}, 32'd0);
        check("rst_m_last", {31'd0, m_last}, 32'd0);
        check("rst_flush_done", {31'd0, flush_done}, 32'd0);
        check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("rst_underflow_err", {31'd0, underflow_err}, 32'd0);
        cycle();
        rd_cnt = 0;
        rst = 1'b0;
        #1;
        check("first_rd_after_rst", {31'd0, fifo_rd_en}, 32'd1);
        cycle(); cycle();
        check("first_beat_not_early", {31'd0, m_valid}, 32'd0);
        cycle();
        check("first_beat_latency", {31'd0, m_valid}, 32'd1);
        idle(8);
        check("stream_rd_count", rd_cnt, 32'd4);
        check("stream_pkt_count", {16'd0, pkt_count}, 32'd2);

        // ---------------- backpressure ----------------
        m_ready = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 6; i++) push_word(16'h0100 + 16'(i));
        expect_beat(32'h0101_0100, 2'b11, 1'b0);
        expect_beat(32'h0103_0102, 2'b11, 1'b0);
        expect_beat(32'h0105_0104, 2'b11, 1'b0);
        #1;
        idle(10);
        check("bp_rd_count", rd_cnt, 32'd4);
        check("bp_hold_valid", {31'd0, m_valid}, 32'd1);
        check("bp_hold_data", m_data, 32'h0101_0100);
        idle(3);
        check("bp_hold_data_later", m_data, 32'h0101_0100);
        m_ready = 1'b1;
        idle(10);
        check("bp_rd_count_total", rd_cnt, 32'd6);
        check("bp_pkt_count", {16'd0, pkt_count}, 32'd5);

        // ---------------- odd flush ----------------
        push_word(16'h000A); push_word(16'h000B); push_word(16'h000C);
        expect_beat(32'h000B_000A, 2'b11, 1'b0);
        expect_beat(32'h0000_000C, 2'b01, 1'b1);
        #1;
        idle(8);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("oflush_wait_no_done", {31'd0, flush_done}, 32'd0);
        cycle();
        check("oflush_done_on_load", {31'd0, flush_done}, 32'd1);
        check("oflush_not_yet_valid", {31'd0, m_valid}, 32'd0);
        cycle();
        check("oflush_valid", {31'd0, m_valid}, 32'd1);
        check("oflush_done_single", {31'd0, flush_done}, 32'd0);
        idle(3);
        check("oflush_pkt_count", {16'd0, pkt_count}, 32'd7);

        // ---------------- empty flush ----------------
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("eflush_done", {31'd0, flush_done}, 32'd1);
        check("eflush_no_beat", {31'd0, m_valid}, 32'd0);
        push_word(16'h0D0D); push_word(16'h0E0E);
        expect_beat(32'h0E0E_0D0D, 2'b11, 1'b0);
        #1;
        check("eflush_reads_held", {31'd0, fifo_rd_en}, 32'd0);
        cycle();
        check("eflush_reads_resume", {31'd0, fifo_rd_en}, 32'd1);
        idle(6);
        check("eflush_pkt_count", {16'd0, pkt_count}, 32'd8);

        // ---------------- underflow injection ----------------
        push_word(16'h0F0F);
        inj_uf = 1'b1;
        #1;
        cycle();
        inj_uf = 1'b0;
        idle(5);
        check("uf_err_set", {31'd0, underflow_err}, 32'd1);
        check("uf_no_beat", {31'd0, m_valid}, 32'd0);
        check("uf_pkt_unchanged", {16'd0, pkt_count}, 32'd8);
        expect_beat(32'h0000_0F0F, 2'b01, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle(5);
        check("uf_staging_intact", {16'd0, pkt_count}, 32'd9);
        check("uf_err_sticky", {31'd0, underflow_err}, 32'd1);

        // ---------------- reset clears sticky state ----------------
        rst = 1'b1;
        cycle();
        check("rst2_underflow_err", {31'd0, underflow_err}, 32'd0);
        check("rst2_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("rst2_m_valid", {31'd0, m_valid}, 32'd0);
        rst = 1'b0;
        idle(2);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
